// File: rtl/led_cmd_ctrl.sv
// LED command controller: UART byte parser (L/B/? commands), debounced key toggle,
// blink phase generator and registered active-low LED drive.
module led_cmd_ctrl #(
    parameter int N_LED      = 6,
    parameter int KEY_CH     = 5,
    parameter int DEB_CYCLES = 270000,
    parameter int BLINK_DIV  = 13500000,
    parameter int TIMEOUT    = 2700000
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [7:0]       in_rx_data,
    input  logic             in_rx_en,
    input  logic             in_key,
    output logic [7:0]       out_tx_data,
    output logic             out_tx_valid,
    input  logic             in_tx_ready,
    output logic [N_LED-1:0] led_out
);
    localparam logic [7:0] OP_L = 8'h4C;
    localparam logic [7:0] OP_B = 8'h42;
    localparam logic [7:0] OP_Q = 8'h3F;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_RESP} state_t;

    state_t           state_q;
    logic             op_l_q;
    logic [TW-1:0]    to_cnt_q;
    logic [N_LED-1:0] state_mask_q;
    logic [N_LED-1:0] blink_mask_q;
    logic [BW-1:0]    blink_cnt_q;
    logic             phase_q;
    logic             key_s1_q;
    logic             key_s2_q;
    logic             key_db_q;
    logic [DW-1:0]    deb_cnt_q;
    logic             key_accept_d;
    logic             key_press_d;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // A new level is taken only after DEB_CYCLES consecutive samples differ from the held one.
    assign key_accept_d = (key_s2_q != key_db_q) && (deb_cnt_q == DW'(DEB_CYCLES - 1));
    assign key_press_d  = key_accept_d && !key_s2_q;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            key_db_q  <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            key_s1_q <= in_key;
            key_s2_q <= key_s1_q;
            if (key_s2_q == key_db_q) begin
                deb_cnt_q <= '0;
            end else if (key_accept_d) begin
                key_db_q  <= key_s2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    // The 'L' write is assigned after the key toggle so it overrides it in the same cycle.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= S_IDLE;
            op_l_q       <= 1'b0;
            to_cnt_q     <= '0;
            state_mask_q <= '0;
            blink_mask_q <= '0;
            out_tx_data  <= 8'h00;
            out_tx_valid <= 1'b0;
        end else begin
            if (key_press_d) begin
                state_mask_q[KEY_CH] <= ~state_mask_q[KEY_CH];
            end
            case (state_q)
                S_IDLE: begin
                    if (in_rx_en) begin
                        if (in_rx_data == OP_L || in_rx_data == OP_B) begin
                            op_l_q   <= (in_rx_data == OP_L);
                            to_cnt_q <= '0;
                            state_q  <= S_ARG;
                        end else begin
                            out_tx_data  <= (in_rx_data == OP_Q) ? 8'(state_mask_q) : NAK;
                            out_tx_valid <= 1'b1;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_ARG: begin
                    if (in_rx_en) begin
                        if (op_l_q) begin
                            state_mask_q <= in_rx_data[N_LED-1:0];
                        end else begin
                            blink_mask_q <= in_rx_data[N_LED-1:0];
                        end
                        out_tx_data  <= ACK;
                        out_tx_valid <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        out_tx_data  <= NAK;
                        out_tx_valid <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (in_tx_ready) begin
                        out_tx_valid <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            led_out <= '1;
        end else begin
            led_out <= ~(state_mask_q & (~blink_mask_q | {N_LED{phase_q}}));
        end
    end
endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Directed bench for led_cmd_ctrl with shortened timing parameters.
module tb_led_cmd_ctrl;
    localparam int N   = 6;
    localparam int KC  = 5;
    localparam int DEB = 8;
    localparam int BD  = 16;
    localparam int TO  = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_en;
    logic         key;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] led;

    int total = 0;
    int bad   = 0;

    led_cmd_ctrl #(
        .N_LED(N), .KEY_CH(KC), .DEB_CYCLES(DEB), .BLINK_DIV(BD), .TIMEOUT(TO)
    ) dut (
        .in_clk(clk), .in_rst(rst_n), .in_rx_data(rx_data), .in_rx_en(rx_en),
        .in_key(key), .out_tx_data(tx_data), .out_tx_valid(tx_valid),
        .in_tx_ready(tx_ready), .led_out(led)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_en   = 1'b1;
        @(negedge clk);
        rx_en   = 1'b0;
    endtask

    task automatic wait_resp(input logic [7:0] exp, input string tag);
        int t = 0;
        while (!tx_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(32'(tx_valid), 1, {tag, " valid"});
        check(32'(tx_data), 32'(exp), {tag, " data"});
        @(negedge clk);
        check(32'(tx_valid), 0, {tag, " one beat"});
    endtask

    task automatic blink_period(input logic [N-1:0] sel, input string tag);
        logic [N-1:0] prev;
        int t;
        prev = led & sel;
        t = 0;
        while ((led & sel) == prev && t < 40) begin
            @(negedge clk);
            t++;
        end
        prev = led & sel;
        t = 0;
        while ((led & sel) == prev && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(32'(t), 32'(BD), {tag, " period"});
        check(32'(led & sel), 32'(~prev & sel), {tag, " alternates"});
    endtask

    initial begin
        logic stable;
        rst_n = 1'b0; rx_data = 8'h00; rx_en = 1'b0; key = 1'b1; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check(32'(led), 32'h3F, "reset led");
        check(32'(tx_valid), 0, "reset valid");
        check(32'(tx_data), 0, "reset data");
        rst_n = 1'b1;
        @(negedge clk);

        // L 0x2A
        send_byte(8'h4C); send_byte(8'h2A);
        wait_resp(8'h06, "L2A ack");
        check(32'(led), 32'h15, "L2A led");

        // blink on bits 1:0
        send_byte(8'h4C); send_byte(8'h03); wait_resp(8'h06, "L03 ack");
        send_byte(8'h42); send_byte(8'h03); wait_resp(8'h06, "B03 ack");
        blink_period(6'b000011, "blink01");
        check(32'(led[5:2]), 32'hF, "blink upper off");
        send_byte(8'h42); send_byte(8'h00); wait_resp(8'h06, "B00 ack");

        // debounce: short press rejected, long press accepted once
        key = 1'b0; repeat (DEB - 1) @(negedge clk);
        key = 1'b1; repeat (5) @(negedge clk);
        check(32'(led[KC]), 1, "short press ignored");
        key = 1'b0; repeat (DEB + 4) @(negedge clk);
        key = 1'b1; repeat (6) @(negedge clk);
        check(32'(led[KC]), 0, "long press toggled");
        send_byte(8'h3F); wait_resp(8'h23, "query after key");
        key = 1'b0; repeat (20) @(negedge clk);
        check(32'(led[KC]), 1, "hold toggled once");
        repeat (16) @(negedge clk);
        check(32'(led[KC]), 1, "hold no repeat");
        key = 1'b1; repeat (20) @(negedge clk);
        check(32'(led[KC]), 1, "release no effect");

        // argument timeout
        send_byte(8'h4C);
        repeat (TO - 1) @(negedge clk);
        check(32'(tx_valid), 0, "timeout not early");
        @(negedge clk);
        check(32'(tx_valid), 1, "timeout valid");
        check(32'(tx_data), 32'h15, "timeout nak");
        @(negedge clk);
        check(32'(tx_valid), 0, "timeout one beat");
        check(32'(led), 32'h3C, "timeout masks kept");
        send_byte(8'h3F); wait_resp(8'h03, "query after timeout");

        // stalled response, byte dropped in RESP
        tx_ready = 1'b0;
        send_byte(8'h3F);
        check(32'(tx_valid), 1, "stall valid");
        check(32'(tx_data), 32'h03, "stall data");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin rx_data = 8'h4C; rx_en = 1'b1; end
            else rx_en = 1'b0;
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h03) stable = 1'b0;
        end
        rx_en = 1'b0;
        check(32'(stable), 1, "stall stable");
        tx_ready = 1'b1;
        @(negedge clk);
        check(32'(tx_valid), 0, "stall released");
        send_byte(8'h3F); wait_resp(8'h03, "query after stall");

        // reset while in ARG
        send_byte(8'h4C);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check(32'(led), 32'h3F, "midrst led");
        check(32'(tx_valid), 0, "midrst valid");
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h42); send_byte(8'h01); wait_resp(8'h06, "B01 ack");
        send_byte(8'h3F); wait_resp(8'h00, "query after rst");
        send_byte(8'h4C); send_byte(8'h01); wait_resp(8'h06, "L01 ack");
        blink_period(6'b000001, "blink0");
        check(32'(led[5:1]), 32'h1F, "blink0 others off");

        // 'L' write and key accept in the same cycle: L wins
        send_byte(8'h4C);
        key = 1'b0;
        repeat (DEB + 1) @(negedge clk);
        send_byte(8'h01);
        wait_resp(8'h06, "collide ack");
        key = 1'b1; repeat (20) @(negedge clk);
        send_byte(8'h3F); wait_resp(8'h01, "collide L wins");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_cmd_ctrl.md
LED_CMD_CTRL -- requirements
Module: led_cmd_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 6, number of LED channels (1..8).
REQ-002 SHALL have parameter KEY_CH, default 5, channel toggled by the key (0..N_LED-1).
REQ-003 SHALL have parameter DEB_CYCLES, default 270000, cycles the key level must stay stable before it is accepted.
REQ-004 SHALL have parameter BLINK_DIV, default 13500000, blink half-period in cycles.
REQ-005 SHALL have parameter TIMEOUT, default 2700000, maximum cycles allowed between the opcode byte and the argument byte.
REQ-006 SHALL have port in_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port in_rst, input, 1 bit, reset, asynchronous, active-low.
REQ-008 SHALL have port in_rx_data, input, 8 bits, received UART byte.
REQ-009 SHALL have port in_rx_en, input, 1 bit, one-cycle strobe marking in_rx_data valid.
REQ-010 SHALL have port in_key, input, 1 bit, raw asynchronous button, active-low (0 = pressed).
REQ-011 SHALL have port out_tx_data, output, 8 bits, response byte.
REQ-012 SHALL have port out_tx_valid, output, 1 bit, response byte available.
REQ-013 SHALL have port in_tx_ready, input, 1 bit, transmitter accepts the byte.
REQ-014 SHALL have port led_out, output, N_LED bits, LED drive, active-low (0 = lit).

Function
REQ-015 SHALL hold registers state_mask[N_LED-1:0] and blink_mask[N_LED-1:0].
REQ-016 SHALL drive led_out[i] = ~(state_mask[i] & (~blink_mask[i] | phase)); led_out is registered, one cycle after any mask change.
REQ-017 SHALL toggle phase every BLINK_DIV cycles using a free-running counter that wraps to 0 after BLINK_DIV-1.
REQ-018 SHALL synchronise in_key through two flops, then debounce: accept a new level only after DEB_CYCLES consecutive equal samples; any glitch restarts the count.
REQ-019 SHALL invert state_mask[KEY_CH] once per accepted 1->0 transition; accepted release (0->1) has no effect; holding the key produces no repeat.
REQ-020 SHALL implement parser FSM states IDLE, ARG, RESP.
REQ-021 IDLE, on in_rx_en: 0x4C ('L') or 0x42 ('B') -> latch opcode, clear timeout counter, go to ARG; 0x3F ('?') -> load response = {zero-extended state_mask}, go to RESP; any other byte -> load response 0x15 (NAK), go to RESP.
REQ-022 ARG, on in_rx_en: 'L' writes state_mask = arg[N_LED-1:0]; 'B' writes blink_mask = arg[N_LED-1:0]; the write takes effect next cycle; arg bits at N_LED and above are ignored; load response 0x06 (ACK), go to RESP.
REQ-023 ARG with no byte for TIMEOUT cycles -> discard opcode, load response 0x15, go to RESP.
REQ-024 RESP: out_tx_valid=1 with out_tx_data stable; transfer occurs on a cycle with out_tx_valid & in_tx_ready; next cycle out_tx_valid=0, state IDLE.
REQ-025 SHALL drop bytes arriving while in RESP, with no state change and no response.
REQ-026 If an 'L' write and an accepted key press occur in the same cycle, the 'L' value SHALL win and the key event is lost.
REQ-027 A key press during ARG or RESP SHALL apply normally; a '?' SHALL report state_mask as of the cycle the '?' byte is accepted.

Reset
REQ-028 SHALL, while in_rst=0, force: state_mask=0, blink_mask=0, phase=0, all counters=0, FSM=IDLE, out_tx_valid=0, out_tx_data=0x00, led_out=all ones, debounced key=1 (released).
REQ-029 SHALL discard any partial command or pending response on reset assertion mid-operation; after release the first byte is treated as an opcode.

Verification
REQ-030 Bytes 0x4C,0x2A with ready=1, N_LED=6 -> state_mask=0x2A, led_out=6'b010101, response 0x06 one beat.
REQ-031 0x42,0x03 after 0x4C,0x03 -> led_out[1:0] alternates 2'b00/2'b11 every BLINK_DIV cycles; other bits stay 1.
REQ-032 in_key low for DEB_CYCLES-1 cycles, high, then low for DEB_CYCLES+4 cycles -> exactly one toggle of bit 5, occurring only after the second pulse.
REQ-033 0x4C then silence for TIMEOUT cycles -> response 0x15, masks unchanged; a following 0x3F -> reply equal to state_mask.
REQ-034 0x3F with in_tx_ready=0 for 10 cycles, then 0x4C arriving during the stall -> out_tx_data stable, 0x4C dropped, state_mask unchanged after ready rises.
REQ-035 in_rst pulsed low in ARG -> led_out all ones, out_tx_valid=0; next 0x42,0x01 -> ACK, blink_mask=0x01.
